// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated alu slice: widths, FSM encoding, opcodes.
package alu_pkg;

   localparam int DW   = 8;   // operand / result width
   localparam int OPW  = 3;   // opcode width
   localparam int CNTW = 16;  // completed-operation counter width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [OPW-1:0] OP_ADD = 3'd0;
   localparam logic [OPW-1:0] OP_SUB = 3'd1;
   localparam logic [OPW-1:0] OP_AND = 3'd2;
   localparam logic [OPW-1:0] OP_OR  = 3'd3;
   localparam logic [OPW-1:0] OP_XOR = 3'd4;
   localparam logic [OPW-1:0] OP_SHL = 3'd5;  // shift amount is b[2:0]
   localparam logic [OPW-1:0] OP_SHR = 3'd6;  // logical, shift amount is b[2:0]
   localparam logic [OPW-1:0] OP_NOT = 3'd7;  // ~a, b ignored

endpackage

// File: rtl/alu.sv
// Shared 8-bit combinational alu; results wrap modulo 256.
module alu
   import alu_pkg::*;
(
   input  logic [DW-1:0]  a_i,
   input  logic [DW-1:0]  b_i,
   input  logic [OPW-1:0] op_i,
   output logic [DW-1:0]  y_o
);

   // Pure opcode decode, no state.
   always_comb begin
      y_o = '0;
      case (op_i)
         OP_ADD:  y_o = a_i + b_i;
         OP_SUB:  y_o = a_i - b_i;
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_XOR:  y_o = a_i ^ b_i;
         OP_SHL:  y_o = a_i << b_i[2:0];
         OP_SHR:  y_o = a_i >> b_i[2:0];
         default: y_o = ~a_i;
      endcase
   end

endmodule

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [IDW-1:0]  winner_o,
   output logic            found_o
);

   int idx;

   // Linear scan from ptr; the first hit wins, later hits are ignored.
   always_comb begin
      winner_o = '0;
      found_o  = 1'b0;
      idx      = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_i) + k) % NREQ;
         if (!found_o && req_i[IDW'(idx)]) begin
            found_o  = 1'b1;
            winner_o = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end sharing one alu among NREQ requesters, one op in flight.
module alu_rr_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*8-1:0] req_a,
   input  logic [NREQ*8-1:0] req_b,
   input  logic [NREQ*3-1:0] req_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [DW-1:0]     rsp_data,
   output logic              busy,
   output logic [CNTW-1:0]   ops_done
);

   state_e          state_q;
   logic [IDW-1:0]  ptr_q, id_q, rsp_id_q;
   logic [DW-1:0]   a_q, b_q, rsp_data_q, alu_y;
   logic [OPW-1:0]  op_q;
   logic            rsp_valid_q;
   logic [CNTW-1:0] ops_done_q;

   logic [IDW-1:0]  winner, ptr_nxt;
   logic            found;
   logic [DW-1:0]   a_arr  [NREQ];
   logic [DW-1:0]   b_arr  [NREQ];
   logic [OPW-1:0]  op_arr [NREQ];

   // Unpack the flat operand buses into per-requester lanes.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         a_arr[i]  = req_a[i*8 +: 8];
         b_arr[i]  = req_b[i*8 +: 8];
         op_arr[i] = req_op[i*3 +: 3];
      end
   end

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req_i    (req_valid),
      .ptr_i    (ptr_q),
      .winner_o (winner),
      .found_o  (found)
   );

   // The alu only ever sees latched operands, so requesters may move on after accept.
   alu u_alu (
      .a_i  (a_q),
      .b_i  (b_q),
      .op_i (op_q),
      .y_o  (alu_y)
   );

   assign ptr_nxt = (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);

   // Grant is combinational in IDLE; gated by rst so it drops the instant reset asserts.
   always_comb begin
      req_ready = '0;
      if (!rst && state_q == IDLE && found) req_ready[winner] = 1'b1;
   end

   // IDLE -> EXEC on a grant, EXEC -> RESP capturing the result, RESP -> IDLE on handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         ops_done_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (found) begin
               a_q     <= a_arr[winner];
               b_q     <= b_arr[winner];
               op_q    <= op_arr[winner];
               id_q    <= winner;
               ptr_q   <= ptr_nxt;
               state_q <= EXEC;
            end
            EXEC: begin
               rsp_data_q  <= alu_y;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: if (rsp_ready) begin
               rsp_valid_q <= 1'b0;
               ops_done_q  <= ops_done_q + CNTW'(1);
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign ops_done  = ops_done_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed + randomized check of alu_rr_arbiter against a transaction-level model.
module tb_alu_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_a, req_b;
   logic [11:0] req_op;
   logic        rsp_valid, rsp_ready;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_data;
   logic        busy;
   logic [15:0] ops_done;

   logic [7:0]  ta [4];
   logic [7:0]  tb_ [4];
   logic [2:0]  top_ [4];

   int          nvec = 0;
   int          nfail = 0;
   int          mptr = 0;        // model round-robin pointer
   logic [15:0] mcnt = '0;       // model completed-op count

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_pack
      assign req_a[g*8 +: 8]  = ta[g];
      assign req_b[g*8 +: 8]  = tb_[g];
      assign req_op[g*3 +: 3] = top_[g];
   end

   alu_rr_arbiter #(.NREQ(4), .IDW(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data),
      .busy(busy), .ops_done(ops_done)
   );

   function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return a << b[2:0];
         3'd6: return a >> b[2:0];
         default: return ~a;
      endcase
   endfunction

   function automatic int rr_win(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++)
         if (v[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete operation from the IDLE cycle through the response handshake.
   task automatic do_op(input int bp);
      int         w;
      logic [7:0] ey;
      w = rr_win(req_valid, mptr);
      chk("grant", {28'd0, req_ready}, 32'd1 << w);
      ey   = ref_alu(ta[w], tb_[w], top_[w]);
      mptr = (w + 1) % 4;
      rsp_ready = (bp == 0);
      tick();
      chk("ready_exec", {28'd0, req_ready}, 32'd0);
      chk("busy_exec", {31'd0, busy}, 32'd1);
      chk("nvalid_exec", {31'd0, rsp_valid}, 32'd0);
      ta[w] = ~ta[w];   // operand change after accept must not leak into the result
      tick();
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_id", {30'd0, rsp_id}, w);
      chk("rsp_data", {24'd0, rsp_data}, {24'd0, ey});
      chk("ready_resp", {28'd0, req_ready}, 32'd0);
      repeat (bp) begin
         tick();
         chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("hold_id", {30'd0, rsp_id}, w);
         chk("hold_data", {24'd0, rsp_data}, {24'd0, ey});
         chk("ready_bp", {28'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      mcnt = mcnt + 16'd1;
      chk("valid_drop", {31'd0, rsp_valid}, 32'd0);
      chk("ops_done", {16'd0, ops_done}, {16'd0, mcnt});
      chk("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int w;
      rst = 1'b1;
      req_valid = 4'hF;
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin ta[i] = '0; tb_[i] = '0; top_[i] = '0; end
      #3;
      // reset state, no clock edge yet
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_id", {30'd0, rsp_id}, 32'd0);
      chk("rst_data", {24'd0, rsp_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_cnt", {16'd0, ops_done}, 32'd0);
      req_valid = 4'h0;
      tick();
      rst = 1'b0;

      // single request, 3C + 05
      ta[0] = 8'h3C; tb_[0] = 8'h05; top_[0] = 3'd0;
      req_valid = 4'b0001;
      #1;
      chk("t1_data_model", {24'd0, ref_alu(8'h3C, 8'h05, 3'd0)}, 32'h41);
      do_op(0);
      req_valid = 4'b0000;
      tick(); tick();
      chk("idle_ready", {28'd0, req_ready}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // all four valid continuously
      for (int i = 0; i < 4; i++) begin
         ta[i] = 8'($urandom); tb_[i] = 8'($urandom); top_[i] = 3'($urandom);
      end
      req_valid = 4'hF;
      #1;
      repeat (5) do_op(0);

      // backpressure for 5 cycles
      do_op(5);

      // operand change after accept: result must reflect FF
      req_valid = 4'b0100;
      ta[2] = 8'hFF; tb_[2] = 8'h00; top_[2] = 3'd3;
      #1;
      do_op(0);

      // randomized traffic
      for (int n = 0; n < 24; n++) begin
         req_valid = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++) begin
            ta[i] = 8'($urandom); tb_[i] = 8'($urandom); top_[i] = 3'($urandom);
         end
         #1;
         do_op($urandom_range(0, 3));
      end

      // reset during EXEC
      req_valid = 4'b1100;
      #1;
      w = rr_win(req_valid, mptr);
      chk("exec_grant", {28'd0, req_ready}, 32'd1 << w);
      tick();
      chk("exec_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("exec_rst_busy", {31'd0, busy}, 32'd0);
      chk("exec_rst_ready", {28'd0, req_ready}, 32'd0);
      chk("exec_rst_cnt", {16'd0, ops_done}, 32'd0);
      tick(); tick();
      chk("exec_rst_noresp", {31'd0, rsp_valid}, 32'd0);
      rst = 1'b0;
      mptr = 0; mcnt = '0;

      // reset during RESP
      req_valid = 4'b0110;
      #1;
      chk("resp_grant", {28'd0, req_ready}, 32'b0010);
      rsp_ready = 1'b0;
      tick(); tick();
      chk("resp_valid_pre", {31'd0, rsp_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("resp_rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("resp_rst_data", {24'd0, rsp_data}, 32'd0);
      chk("resp_rst_id", {30'd0, rsp_id}, 32'd0);
      chk("resp_rst_busy", {31'd0, busy}, 32'd0);
      tick();
      rst = 1'b0;
      mptr = 0;
      req_valid = 4'b1110;
      #1;
      do_op(0);   // lowest valid index from ptr 0 is requester 1

      // ops_done wrap
      req_valid = 4'b0000;
      force dut.ops_done_q = 16'hFFFE;
      #1;
      release dut.ops_done_q;
      mcnt = 16'hFFFE;
      tick();
      chk("wrap_preload", {16'd0, ops_done}, 32'hFFFE);
      req_valid = 4'b1001;
      #1;
      do_op(0);
      do_op(1);
      chk("wrap_zero", {16'd0, ops_done}, 32'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
